// File: rtl/arm_motion_sequencer_pkg.sv
// Shared encodings and frame constants for the arm motion sequencer.
// The servo step controller imports the same frame length.
package arm_seq_pkg;

    localparam int DWELL_UNIT_DEF = 2_000_000;
    localparam int NUM_STEPS_DEF  = 8;
    localparam int DWELL_W_DEF    = 6;
    localparam int CNT_W          = 22;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CW   = 2'b01,
        OP_CCW  = 2'b10,
        OP_END  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DWELL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/arm_motion_sequencer_if.sv
// Command/status bundle between the motion sequencer and its host.
// The master side is the sequencer; the slave side drives start/abort/pause.
interface arm_motion_sequencer_if #(
    parameter int PC_W = 3
);
    logic            start;
    logic            abort;
    logic            pause;
    logic            step_cw;
    logic            step_ccw;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [PC_W-1:0] pc;

    modport master (
        input  start, abort, pause,
        output step_cw, step_ccw, busy, done, aborted, pc
    );

    modport slave (
        output start, abort, pause,
        input  step_cw, step_ccw, busy, done, aborted, pc
    );
endinterface

// File: rtl/arm_motion_sequencer_rom.sv
// Motion program ROM: entry = {op, dwell}. Replace this module to load
// a different arm program; unused slots must hold END.
module arm_seq_rom
    import arm_seq_pkg::*;
#(
    parameter int PC_W    = 3,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic [PC_W-1:0]    pc,
    output logic [DWELL_W+1:0] entry
);

    always_comb begin
        entry = {OP_END, DWELL_W'(0)};
        case (pc)
            PC_W'(0): entry = {OP_CW,   DWELL_W'(10)};
            PC_W'(1): entry = {OP_CW,   DWELL_W'(10)};
            PC_W'(2): entry = {OP_HOLD, DWELL_W'(25)};
            PC_W'(3): entry = {OP_CCW,  DWELL_W'(10)};
            PC_W'(4): entry = {OP_CCW,  DWELL_W'(10)};
            default:  entry = {OP_END,  DWELL_W'(0)};
        endcase
    end

endmodule

// File: rtl/arm_motion_sequencer.sv
// Plays the ROM motion program as single-cycle step pulses with per-entry
// dwell measured in servo frames.
//
//  state | meaning
//  IDLE  | waiting for start, busy low
//  FETCH | latch rom[pc] into op_q/dwell_q
//  ISSUE | step pulse (if any) visible, decide END / advance / dwell
//  DWELL | count dwell_q frames of DWELL_UNIT clocks, frozen by pause
//  DONE  | done pulse, back to IDLE
module arm_motion_sequencer
    import arm_seq_pkg::*;
#(
    parameter int DWELL_UNIT = DWELL_UNIT_DEF,
    parameter int NUM_STEPS  = NUM_STEPS_DEF,
    parameter int DWELL_W    = DWELL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    arm_motion_sequencer_if.master bus
);

    localparam int                PC_W      = $clog2(NUM_STEPS);
    localparam logic [CNT_W-1:0]  UNIT_LAST = CNT_W'(DWELL_UNIT - 1);
    localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(NUM_STEPS - 1);

    state_t               state;
    op_t                  op_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   remaining;
    logic [CNT_W-1:0]     unit_cnt;
    logic [PC_W-1:0]      pc_q;
    logic [DWELL_W+1:0]   rom_entry;
    op_t                  rom_op;
    logic                 step_cw_q, step_ccw_q, busy_q, done_q, aborted_q;

    arm_seq_rom #(.PC_W(PC_W), .DWELL_W(DWELL_W)) u_rom (
        .pc    (pc_q),
        .entry (rom_entry)
    );

    assign rom_op = op_t'(rom_entry[DWELL_W+1 -: 2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_HOLD;
            dwell_q    <= '0;
            remaining  <= '0;
            unit_cnt   <= '0;
            pc_q       <= '0;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            // abort outranks everything, including a coincident start
            if (bus.abort && state != ST_IDLE) begin
                state     <= ST_IDLE;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state  <= ST_FETCH;
                            pc_q   <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        op_q       <= rom_op;
                        dwell_q    <= rom_entry[DWELL_W-1:0];
                        step_cw_q  <= (rom_op == OP_CW);
                        step_ccw_q <= (rom_op == OP_CCW);
                        state      <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (op_q == OP_END) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else if (dwell_q == '0) begin
                            if (pc_q == PC_LAST) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
                                pc_q  <= pc_q + 1'b1;
                                state <= ST_FETCH;
                            end
                        end else begin
                            unit_cnt  <= '0;
                            remaining <= dwell_q;
                            state     <= ST_DWELL;
                        end
                    end
                    ST_DWELL: begin
                        if (!bus.pause) begin
                            if (unit_cnt == UNIT_LAST) begin
                                unit_cnt  <= '0;
                                remaining <= remaining - 1'b1;
                                if (remaining == DWELL_W'(1)) begin
                                    if (pc_q == PC_LAST) begin
                                        state  <= ST_DONE;
                                        done_q <= 1'b1;
                                    end else begin
                                        pc_q  <= pc_q + 1'b1;
                                        state <= ST_FETCH;
                                    end
                                end
                            end else begin
                                unit_cnt <= unit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.step_cw  = step_cw_q;
    assign bus.step_ccw = step_ccw_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.aborted  = aborted_q;
    assign bus.pc       = pc_q;

endmodule
